arb_mux_n: RTL
==============

Name: arb_mux_n

Overview:
- Parametrised, registered N:1 operand/result multiplexer. Successor to the gate-level 2:1 select cell.
- Arbitrates among NCH valid/ready input channels of WIDTH bits each, and drives one registered output stage with a valid/ready handshake.
- Sits between ALU/forwarding sources and the writeback/operand bus, wherever more than one producer competes for one consumer.

Parameters:
- WIDTH, 32, data width per channel in bits (1..64).
- NCH, 4, number of input channels (2..8).
- SELW, 2, channel-index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready=0 while rst=1.
- load_en = ~out_valid | out_ready (combinational). The output register accepts new data when empty or being drained in the same cycle.
- Grant (combinational):
  - Round-robin (mode=0): the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NCH.
  - Fixed (mode=1): the lowest i with in_valid[i]=1.
  - No valid inputs: no grant.
- in_ready[i] = grant[i] & load_en. At most one bit is set. A transfer on channel i happens when in_valid[i] & in_ready[i].
- On an input transfer at the rising edge: out_data <= channel-i data; out_chan <= i; out_valid <= 1. In mode 0, rr_ptr <= (i+1) mod NCH; in mode 1, rr_ptr is unchanged.
- If out_valid & out_ready with no input transfer: out_valid <= 0. out_data and out_chan hold their last values.
- If out_valid & ~out_ready: out_data, out_chan and out_valid all hold, and in_ready=0 for all channels.
- Latency: 1 cycle from input transfer to out_valid. Full throughput is one transfer per cycle when out_ready stays high.
- Wrap-around: rr_ptr after channel NCH-1 is 0.
- mode may change on any cycle and takes effect on the same-cycle grant. rr_ptr is retained across mode changes.
- in_valid[i] may drop without a transfer; no state changes result.
- rst asserted mid-transfer: the output is discarded immediately and no partial state survives.
- No combinational path from in_data to out_data. in_ready depends combinationally on in_valid, mode, rr_ptr, out_valid and out_ready only.

Optional Feature:
- Macro: ARB_MUX_STALL_CNT_EN.
- Defined: adds output port stall_cnt (output, 16 bits).
  - Increments each cycle out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF; never wraps.
  - Reset to 0 by rst.
  - Holds otherwise; it is not cleared by a transfer.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan (NCH=4, WIDTH=8):
1. Reset: assert rst mid-run with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 immediately, without waiting for clk.
2. Round-robin fairness: mode=0, in_valid=4'b1111, data 8'hA0..8'hA3, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, out_data A0,A1,A2,A3,..., out_valid=1 from cycle 2 onward.
3. Fixed priority: mode=1, in_valid=4'b1010 held, out_ready=1 -> every transfer from channel 1 (8'hA1), channel 3 never granted, rr_ptr unchanged.
4. Back-pressure: out_ready=0 for 3 cycles after one load of 8'h5C on channel 2 -> out_data=5C, out_chan=2 held, in_ready=0000. With the macro defined, stall_cnt=3. Raising out_ready drains, and the next grant is channel 3.
5. Wrap/sparse: mode=0, rr_ptr=3, in_valid=4'b0001 -> channel 0 granted, rr_ptr becomes 1. Then in_valid=4'b1001 -> channel 3 granted.
6. Counter saturation (macro defined): hold out_valid=1, out_ready=0 for 65540 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N:1 valid/ready arbiter-multiplexer.
// Picks one of NCH producers (round-robin or fixed priority) into one output register.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   mode            - 0 round-robin, 1 fixed priority (lowest index wins)
//   in_data         - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid        - per-channel valid
//   in_ready        - per-channel ready (one-hot or zero)
//   out_data        - registered selected data
//   out_valid       - registered output valid
//   out_ready       - downstream ready
//   out_chan        - registered index of the producing channel
//   stall_cnt       - saturating stall counter (only with ARB_MUX_STALL_CNT_EN)
// Optional macro: ARB_MUX_STALL_CNT_EN adds the 16-bit stall_cnt output.

module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
`ifdef ARB_MUX_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    logic [WIDTH-1:0] ch_data [NCH];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW-1:0]  rr_nxt;
    logic             load_en;
    logic             xfer;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the far end down so the nearest candidate is written last.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                j = int'(rr_ptr_q) + k;
                if (j >= NCH) begin
                    j = j - NCH;
                end
                if (in_valid[SELW'(j)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(j);
                end
            end
        end
    end

    assign load_en = ~out_valid_q | out_ready;
    assign xfer    = gnt_vld & load_en;

    assign rr_nxt = (int'(gnt_idx) == NCH - 1) ? '0
                  : gnt_idx + SELW'(1);

    // Held low during reset even though the cleared output looks empty.
    always_comb begin
        in_ready = '0;
        if (!rst && xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt_idx];
            out_chan_d  = gnt_idx;
            if (!mode) begin
                rr_ptr_d = rr_nxt;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef ARB_MUX_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
